// File: rtl/prbs_pkg.sv
// Shared PRBS9 constants, sequencer state encoding and the LFSR step function.
package prbs_pkg;

  localparam int PRBS9_LEN    = 9;
  localparam int PRBS9_PERIOD = 511;
  localparam int PRBS9_TAP_A  = 8;
  localparam int PRBS9_TAP_B  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    BER  = 2'd2
  } state_t;

  // x^9 + x^5 + 1, shifting toward the MSB which is the output bit
  function automatic logic [PRBS9_LEN-1:0] prbs9_next(input logic [PRBS9_LEN-1:0] v);
    return {v[PRBS9_LEN-2:0], v[PRBS9_TAP_A] ^ v[PRBS9_TAP_B]};
  endfunction

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 generator register: load-to-seed has priority over a step.
module prbs9_lfsr
  import prbs_pkg::*;
#(
  parameter logic [PRBS9_LEN-1:0] SEED = 9'h1AA
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_step,
  output logic o_bit
);

  logic [PRBS9_LEN-1:0] lfsr;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset)     lfsr <= SEED;
    else if (i_load) lfsr <= SEED;
    else if (i_step) lfsr <= prbs9_next(lfsr);
  end

  assign o_bit = lfsr[PRBS9_LEN-1];

endmodule

// File: rtl/prbs_tx_sequencer.sv
// PRBS9 transmit sequencer: IDLE -> SYNC latency sweep -> BER counting.
// Optional error injection on the channel bit under macro PRBS_TX_ERR_INJ_EN.
module prbs_tx_sequencer
  import prbs_pkg::*;
#(
  parameter logic [8:0] SEED         = 9'h1AA,
  parameter int         SYNC_PERIODS = 511,
  parameter int         ERR_PERIOD   = 1024
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_ctrl,
  input  logic       i_en_tx,
  input  logic       i_restart_sync,
  input  logic       i_err_inj_en,
  output logic       o_tx_bit,
  output logic       o_new_bit_from_prbs,
  output logic       o_prbs_cmp_curr_addr_done,
  output logic       o_synchro_en,
  output logic       o_ber_counter_en,
  output logic [8:0] o_sweep_idx
);

  localparam logic [8:0] LAST_BIT   = 9'(PRBS9_PERIOD - 1);
  localparam logic [8:0] LAST_SWEEP = 9'(SYNC_PERIODS - 1);

  state_t     state, state_nxt;
  logic [8:0] bit_idx, bit_idx_nxt, bit_adv;
  logic [8:0] sweep_idx, sweep_nxt;
  logic       done_q, done_nxt;
  logic       bit_wrap;
  logic       lfsr_load, lfsr_step;
  logic       prbs_bit;

  prbs9_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .i_reset (i_reset),
    .i_load  (lfsr_load),
    .i_step  (lfsr_step),
    .o_bit   (prbs_bit)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      sweep_idx <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_idx   <= bit_idx_nxt;
      sweep_idx <= sweep_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bit_wrap = (bit_idx == LAST_BIT);
  assign bit_adv  = bit_wrap ? 9'd0 : bit_idx + 9'd1;

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    sweep_nxt   = sweep_idx;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    if (!i_en_tx) begin
      state_nxt   = IDLE;
      bit_idx_nxt = '0;
      sweep_nxt   = '0;
      lfsr_load   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          lfsr_load   = 1'b1;
          bit_idx_nxt = '0;
          sweep_nxt   = '0;
          if (i_ctrl) state_nxt = SYNC;
        end
        SYNC: begin
          if (i_ctrl) begin
            lfsr_step   = 1'b1;
            bit_idx_nxt = bit_adv;
            if (bit_wrap) begin
              if (sweep_idx == LAST_SWEEP) state_nxt = BER;
              else                         sweep_nxt = sweep_idx + 9'd1;
            end
          end
        end
        BER: begin
          // restart keeps the LFSR running so the receiver's phase survives
          if (i_ctrl) begin
            lfsr_step   = 1'b1;
            bit_idx_nxt = bit_adv;
            if (i_restart_sync) begin
              state_nxt = SYNC;
              sweep_nxt = '0;
            end
          end
        end
        default: begin
          state_nxt   = IDLE;
          bit_idx_nxt = '0;
          sweep_nxt   = '0;
          lfsr_load   = 1'b1;
        end
      endcase
    end
    done_nxt = (bit_idx_nxt == LAST_BIT);
  end

  assign o_new_bit_from_prbs       = prbs_bit;
  assign o_prbs_cmp_curr_addr_done = done_q;
  assign o_synchro_en              = (state == SYNC);
  assign o_ber_counter_en          = (state == BER);
  assign o_sweep_idx               = sweep_idx;

`ifdef PRBS_TX_ERR_INJ_EN
  localparam int CNT_W = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ERR_PERIOD - 1);

  logic [CNT_W-1:0] inj_cnt;
  logic             inj_flag;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset)                               inj_cnt <= '0;
    else if (state != BER || !i_err_inj_en)    inj_cnt <= '0;
    else if (i_ctrl)                           inj_cnt <= (inj_cnt == LAST_CNT) ? '0 : inj_cnt + CNT_W'(1);
  end

  assign inj_flag = (state == BER) && (inj_cnt == LAST_CNT);
  assign o_tx_bit = prbs_bit ^ inj_flag;
`else
  logic unused_inj;
  assign unused_inj = i_err_inj_en ^ (ERR_PERIOD == 0);
  assign o_tx_bit   = prbs_bit;
`endif

endmodule

// File: tb/tb_prbs_tx_sequencer.sv
// Directed bench for prbs_tx_sequencer with SYNC_PERIODS=4, ERR_PERIOD=8.
module tb_prbs_tx_sequencer;

  localparam logic [8:0] SEED = 9'h1AA;
`ifdef PRBS_TX_ERR_INJ_EN
  localparam int INJ_ON = 1;
`else
  localparam int INJ_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       i_reset, i_ctrl, i_en_tx, i_restart_sync, i_err_inj_en;
  logic       o_tx_bit, o_new_bit_from_prbs, o_prbs_cmp_curr_addr_done;
  logic       o_synchro_en, o_ber_counter_en;
  logic [8:0] o_sweep_idx;

  int errors = 0;
  int checks = 0;

  bit model [0:510];
  bit dut_bits [0:1021];

  always #5 clk = ~clk;

  prbs_tx_sequencer #(.SEED(SEED), .SYNC_PERIODS(4), .ERR_PERIOD(8)) dut (
    .clk                       (clk),
    .i_reset                   (i_reset),
    .i_ctrl                    (i_ctrl),
    .i_en_tx                   (i_en_tx),
    .i_restart_sync            (i_restart_sync),
    .i_err_inj_en              (i_err_inj_en),
    .o_tx_bit                  (o_tx_bit),
    .o_new_bit_from_prbs       (o_new_bit_from_prbs),
    .o_prbs_cmp_curr_addr_done (o_prbs_cmp_curr_addr_done),
    .o_synchro_en              (o_synchro_en),
    .o_ber_counter_en          (o_ber_counter_en),
    .o_sweep_idx               (o_sweep_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] m;
    logic [8:0] first9;
    int n, ones, done_cnt, done_err, sync_cnt, strm_err, per_err;
    int inj_diffs, inj_bad, budget, j, seq_err, hold_err;
    bit prev_bit, prev_sync;
    logic [8:0] prev_sweep;

    m = SEED;
    for (int i = 0; i < 511; i++) begin
      model[i] = m[8];
      m = {m[7:0], m[8] ^ m[4]};
    end

    i_reset = 1'b1; i_ctrl = 1'b0; i_en_tx = 1'b0;
    i_restart_sync = 1'b0; i_err_inj_en = 1'b1;
    #12;
    check("rst_tx",    o_tx_bit, 1);
    check("rst_nb",    o_new_bit_from_prbs, 1);
    check("rst_done",  o_prbs_cmp_curr_addr_done, 0);
    check("rst_sync",  o_synchro_en, 0);
    check("rst_ber",   o_ber_counter_en, 0);
    check("rst_sweep", o_sweep_idx, 0);

    // continuous strobe from reset release through SYNC into BER
    i_reset = 1'b0; i_en_tx = 1'b1; i_ctrl = 1'b1;
    n = 0; ones = 0; done_cnt = 0; done_err = 0; sync_cnt = 0; strm_err = 0;
    inj_diffs = 0; inj_bad = 0;
    while (n < 2084) begin
      i_restart_sync = (n == 599);
      step(); n++;
      i_restart_sync = 1'b0;
      if (o_new_bit_from_prbs !== model[(n-1) % 511]) strm_err++;
      if (n <= 1022) begin
        dut_bits[n-1] = o_new_bit_from_prbs;
        if (o_prbs_cmp_curr_addr_done) done_cnt++;
        if (o_prbs_cmp_curr_addr_done !== (((n-1) % 511) == 510)) done_err++;
      end
      if (n <= 511) ones += int'(o_new_bit_from_prbs);
      if (o_synchro_en) sync_cnt++;
      if (n == 1 || n == 512 || n == 1023 || n == 1534)
        check("sweep_step", o_sweep_idx, (n-1) / 511);
      if (n == 600) check("restart_in_sync_ignored", o_sweep_idx, 1);
      if (n == 2044) check("ber_not_yet", o_ber_counter_en, 0);
      if (n == 2045) begin
        check("ber_rise",  o_ber_counter_en, 1);
        check("sync_fall", o_synchro_en, 0);
      end
      if (n >= 2045 && n <= 2074) begin
        if (o_tx_bit !== o_new_bit_from_prbs) inj_diffs++;
        if ((o_tx_bit ^ o_new_bit_from_prbs) !== (INJ_ON == 1 && ((n-2044) % 8) == 0)) inj_bad++;
      end
    end
    for (int i = 0; i < 9; i++) first9[8-i] = dut_bits[i];
    check("first9_bits", first9, 9'b110101010);
    check("ones_per_period", ones, 256);
    per_err = 0;
    for (int k = 0; k < 511; k++) if (dut_bits[k] != dut_bits[k+511]) per_err++;
    check("period_511", per_err, 0);
    check("done_count", done_cnt, 2);
    check("done_position", done_err, 0);
    check("sync_len", sync_cnt, 2044);
    check("inj_diff_count", inj_diffs, 3 * INJ_ON);
    check("inj_positions", inj_bad, 0);

    // restart from BER: back to SYNC, stream continues
    i_restart_sync = 1'b1;
    step(); n++;
    i_restart_sync = 1'b0;
    check("restart_sync", o_synchro_en, 1);
    check("restart_ber", o_ber_counter_en, 0);
    check("restart_sweep", o_sweep_idx, 0);
    budget = 0;
    while (!o_ber_counter_en && budget < 3000) begin
      step(); n++; budget++;
      if (o_new_bit_from_prbs !== model[(n-1) % 511]) strm_err++;
    end
    check("stream_continuity", strm_err, 0);
    check("reenter_ber_timeout", o_ber_counter_en, 1);

    // disable wins over restart on the same strobe
    i_en_tx = 1'b0; i_restart_sync = 1'b1;
    step();
    i_restart_sync = 1'b0;
    check("dis_sync", o_synchro_en, 0);
    check("dis_ber", o_ber_counter_en, 0);
    check("dis_sweep", o_sweep_idx, 0);
    check("dis_tx", o_tx_bit, 1);
    check("dis_done", o_prbs_cmp_curr_addr_done, 0);

    // strobe one clock in four: same stream, outputs hold between strobes
    i_reset = 1'b1; #1; i_reset = 1'b0;
    i_en_tx = 1'b1;
    j = 0; seq_err = 0; hold_err = 0;
    prev_bit = o_new_bit_from_prbs; prev_sync = o_synchro_en; prev_sweep = o_sweep_idx;
    for (int c = 0; c < 2400; c++) begin
      i_ctrl = ((c % 4) == 0);
      step();
      if (i_ctrl) begin
        if (j < 600 && o_new_bit_from_prbs !== dut_bits[j]) seq_err++;
        j++;
      end else if (o_new_bit_from_prbs !== prev_bit || o_synchro_en !== prev_sync ||
                   o_sweep_idx !== prev_sweep) begin
        hold_err++;
      end
      prev_bit = o_new_bit_from_prbs; prev_sync = o_synchro_en; prev_sweep = o_sweep_idx;
    end
    check("slow_stream", seq_err, 0);
    check("slow_hold", hold_err, 0);
    check("slow_sweep", o_sweep_idx, 1);

    // disable without a strobe still forces IDLE
    i_ctrl = 1'b0; i_en_tx = 1'b0;
    step();
    check("dis_nostrobe_sync", o_synchro_en, 0);
    check("dis_nostrobe_sweep", o_sweep_idx, 0);
    check("dis_nostrobe_tx", o_tx_bit, 1);

    // asynchronous reset mid-SYNC between edges
    i_en_tx = 1'b1; i_ctrl = 1'b1;
    for (int c = 0; c < 520; c++) step();
    check("pre_areset_sweep", o_sweep_idx, 1);
    #3 i_reset = 1'b1;
    #1;
    check("areset_sync", o_synchro_en, 0);
    check("areset_sweep", o_sweep_idx, 0);
    check("areset_tx", o_tx_bit, 1);
    check("areset_nb", o_new_bit_from_prbs, 1);
    check("areset_done", o_prbs_cmp_curr_addr_done, 0);
    check("areset_ber", o_ber_counter_en, 0);
    i_reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prbs_tx_sequencer.md
# prbs_tx_sequencer

Transmit-side counterpart of the receive BER counter. Generates the PRBS9 reference stream at the baud-rate strobe and drives the link with it. Sequences the link through idle, synchronization sweep and BER-counting phases. Drives the receiver's strobe-qualified control inputs: new PRBS bit, per-period done, synchro enable and BER-count enable.

## Interface
Parameters:
- SEED, 9'h1AA: LFSR load value. Must be nonzero.
- SYNC_PERIODS, 511: number of full PRBS periods spent in SYNC, one per candidate latency.
- ERR_PERIOD, 1024: bits between injected errors. Only used with the injection macro.

Ports:
- clk, in, 1: single clock.
- i_reset, in, 1: asynchronous, active-high reset.
- i_ctrl, in, 1: baud-rate strobe. Nothing advances unless it is high.
- i_en_tx, in, 1: link enable. Low forces IDLE synchronously.
- i_restart_sync, in, 1: single-cycle request to rerun the sweep. Sampled on strobe cycles.
- i_err_inj_en, in, 1: error-injection enable. Ignored unless the macro is defined.
- o_tx_bit, out, 1: bit to the channel.
- o_new_bit_from_prbs, out, 1: clean PRBS bit for the receiver shifter.
- o_prbs_cmp_curr_addr_done, out, 1: high during the last bit of each period.
- o_synchro_en, out, 1: high in SYNC.
- o_ber_counter_en, out, 1: high in BER.
- o_sweep_idx, out, 9: index of the current SYNC period.

## Operation
- LFSR:
  - PRBS9, polynomial x^9+x^5+1, 9-bit register.
  - Output bit = lfsr[8].
  - Update on strobe: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}.
- Bit index counter:
  - Counts 0..510 and wraps 510→0.
  - o_prbs_cmp_curr_addr_done is registered and equals (bit_idx==510).
- FSM states:
  - IDLE: LFSR = SEED, bit_idx = 0, sweep_idx = 0, all enables low.
    - Exit to SYNC on the first strobe with i_en_tx=1.
  - SYNC: LFSR and bit_idx advance each strobe.
    - On the strobe where bit_idx wraps, sweep_idx increments.
    - When sweep_idx reaches SYNC_PERIODS-1 and wraps, go to BER.
  - BER: LFSR and bit_idx keep advancing, sweep_idx is held.
    - i_restart_sync=1 on a strobe → SYNC with sweep_idx=0. LFSR and bit_idx continue, so phase is preserved.
  - Any state with i_en_tx=0 → IDLE on the next clock, whether or not a strobe is present.
- No strobe (i_ctrl=0): every register is held.
- o_synchro_en = (state==SYNC).
- o_ber_counter_en = (state==BER).
- o_new_bit_from_prbs = lfsr[8] in every state.
- o_tx_bit = lfsr[8], XORed with the injection flag when the macro is enabled.
- Simultaneous events:
  - i_restart_sync in SYNC or IDLE is ignored.
  - i_en_tx=0 has priority over i_restart_sync and over the SYNC→BER transition.

## Timing
- Reset values:
  - state IDLE, lfsr SEED, bit_idx 0, sweep_idx 0, injection counter 0.
  - o_tx_bit = o_new_bit_from_prbs = SEED[8] = 1.
  - o_prbs_cmp_curr_addr_done 0, o_synchro_en 0, o_ber_counter_en 0, o_sweep_idx 0.
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.
- An output changes one clock after the strobe that caused it, and is valid for the next strobe. This matches the receiver sampling on i_ctrl.
- Total SYNC duration = SYNC_PERIODS×511 strobes. o_synchro_en falls and o_ber_counter_en rises in the same clock.
- Reset mid-operation returns all registers to their reset values immediately, without waiting for a clock.

## Configuration
- Macro PRBS_TX_ERR_INJ_EN.
- Defined:
  - In BER with i_err_inj_en=1, a counter counts strobes 0..ERR_PERIOD-1.
  - On count ERR_PERIOD-1, o_tx_bit is inverted for that bit.
  - The counter clears whenever it is not counting, so the first injected error falls on the ERR_PERIOD-th BER bit.
  - o_new_bit_from_prbs is never corrupted.
- Undefined: the counter logic is absent, i_err_inj_en is unconnected, and o_tx_bit ≡ o_new_bit_from_prbs.

## Structure
- Package prbs_pkg holds:
  - PRBS9_LEN=9, PRBS9_PERIOD=511, the tap positions (8,4).
  - The FSM state encoding IDLE=2'd0, SYNC=2'd1, BER=2'd2. 2'd3 is illegal and recovers to IDLE.
- Sub-module prbs9_lfsr (inputs clk, i_reset, i_load, i_step; parameter SEED; output o_bit) is instantiated once.
- The FSM, counters and injection logic live in the top.

## Test plan
- Reset release with i_en_tx=1 and continuous strobe:
  - First o_tx_bit = 1.
  - Sequence repeats with period exactly 511 and contains 256 ones per period.
  - o_prbs_cmp_curr_addr_done is high for 1 strobe in 511.
- SYNC_PERIODS=4: o_synchro_en is high for exactly 2044 strobes, then o_ber_counter_en=1, with o_sweep_idx stepping 0,1,2,3.
- i_ctrl high only 1 clock in 4: output changes only after strobe clocks; stream is identical bit-for-bit to the continuous-strobe case.
- In BER, pulse i_restart_sync:
  - Back to SYNC with o_sweep_idx=0.
  - The LFSR sequence shows no discontinuity.
  - i_en_tx=0 in the same cycle → IDLE instead.
- Async i_reset asserted mid-SYNC between clock edges: all outputs go to reset values before the next edge.
- Macro defined, ERR_PERIOD=8, i_err_inj_en=1 in BER:
  - o_tx_bit differs from o_new_bit_from_prbs on BER bits 8, 16, 24 only.
  - Without the macro, no difference.
